tms1x00_seq: RTL and testbench

TMS1X00_SEQ -- requirements
Module: tms1x00_seq

---
 rtl/tms1x00_pkg.sv | 54 +++++
 rtl/tms1x00_retstack.sv | 57 +++++
 rtl/tms1x00_seq.sv | 146 ++++++++++++++
 tb/tb_tms1x00_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tms1x00_pkg.sv
// Shared definitions for the TMS1x00 program sequencer: opcode encodings,
// address field widths, the instruction-class decoder and the 6-bit
// feedback-shift PC successor function.
package tms1x00_pkg;

    localparam int ROM_PAGE_BITS = 4;
    localparam int PC_BITS       = 6;

    localparam logic [7:0] OP_RETN     = 8'h0F;
    localparam logic [7:0] OP_COMC     = 8'h0B;
    localparam logic [3:0] OP_LDP_PFX  = 4'b0001;
    localparam logic [1:0] OP_BR_PFX   = 2'b10;
    localparam logic [1:0] OP_CALL_PFX = 2'b11;

    typedef enum logic [2:0] {
        OPC_NONE,
        OPC_LDP,
        OPC_COMC,
        OPC_RETN,
        OPC_BR,
        OPC_CALL
    } op_class_t;

    // The PC is a shift register, not a binary counter. The two special
    // cases splice 0x3F into the XNOR sequence so all 64 codes are visited.
    function automatic logic [PC_BITS-1:0] pc_next(input logic [PC_BITS-1:0] pc);
        logic [PC_BITS-1:0] nxt;
        if (pc == 6'h1F)
            nxt = 6'h3F;
        else if (pc == 6'h3F)
            nxt = 6'h3E;
        else
            nxt = {pc[4:0], ~(pc[5] ^ pc[4])};
        return nxt;
    endfunction

    // comc_ok is low when 0x0B has no chapter meaning in this build.
    function automatic op_class_t op_decode(input logic [7:0] op, input logic comc_ok);
        op_class_t cls;
        cls = OPC_NONE;
        if (op[7:6] == OP_CALL_PFX)
            cls = OPC_CALL;
        else if (op[7:6] == OP_BR_PFX)
            cls = OPC_BR;
        else if (op[7:4] == OP_LDP_PFX)
            cls = OPC_LDP;
        else if (op == OP_RETN)
            cls = OPC_RETN;
        else if (op == OP_COMC && comc_ok)
            cls = OPC_COMC;
        return cls;
    endfunction

endpackage

// File: rtl/tms1x00_retstack.sv
// Return-address LIFO for the sequencer; DEPTH entries of WIDTH bits.
// Latency: push/pop take effect on the next clk; pop_dat is the current top (combinational read).
// Backpressure: push while full and pop while empty are ignored; the caller decides overflow policy.
// Ports: clk, reset (sync, active-high), push/pop + push_dat, pop_dat, count, full, empty.
module tms1x00_retstack #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_dat,
    output logic [WIDTH-1:0] pop_dat,
    output logic [2:0]       count,
    output logic             full,
    output logic             empty
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [2:0]       cnt_q, cnt_d;
    logic [IW-1:0]    wr_idx, rd_idx;

    assign empty   = (cnt_q == 3'd0);
    assign full    = (cnt_q == 3'(DEPTH));
    assign count   = cnt_q;
    assign wr_idx  = IW'(cnt_q);
    // Guarded so the read index never wraps out of the array when empty.
    assign rd_idx  = empty ? '0 : IW'(cnt_q - 3'd1);
    assign pop_dat = mem_q[rd_idx];

    always_comb begin
        mem_d = mem_q;
        cnt_d = cnt_q;
        if (push && !full) begin
            mem_d[wr_idx] = push_dat;
            cnt_d         = cnt_q + 3'd1;
        end else if (pop && !empty) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    // Entries above the count are never read, so the storage needs no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= 3'd0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tms1x00_seq.sv
// TMS1000/TMS1100 program sequencer: PC shift register, page/chapter + buffers, call/return stack.
// Latency: rom_addr shows the effect of a step one clk after the step edge; no opcode->rom_addr path.
// Backpressure: none; step=0 freezes all state, CALL with a full stack degrades to a branch + sticky stack_ovf.
// Ports: clk, reset, step, opcode[7:0], status -> rom_addr, level[2:0], in_sub, stack_ovf.
module tms1x00_seq
    import tms1x00_pkg::*;
#(
    parameter int CHAPTER_BITS = 0,
    parameter int STACK_DEPTH  = 1,
    parameter int COMC_EN      = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      step,
    input  logic [7:0]                opcode,
    input  logic                      status,
    output logic [CHAPTER_BITS+9:0]   rom_addr,
    output logic [2:0]                level,
    output logic                      in_sub,
    output logic                      stack_ovf
);
    localparam int ADDR_W = CHAPTER_BITS + 10;
    localparam logic COMC_OK = (COMC_EN != 0) && (CHAPTER_BITS == 1);

    logic [PC_BITS-1:0]       pc_q, pc_d, pc_inc;
    logic [ROM_PAGE_BITS-1:0] page_q, page_d, pb_q, pb_d;
    logic                     chapter_q, chapter_d, cb_q, cb_d;
    logic                     ovf_q, ovf_d;

    logic                     push, pop, stk_full, stk_empty;
    logic [ADDR_W-1:0]        push_dat, pop_dat;
    logic [ROM_PAGE_BITS-1:0] pop_page;
    logic [PC_BITS-1:0]       pop_pc;
    logic                     pop_chap;
    op_class_t                op_cls;

    tms1x00_retstack #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (ADDR_W)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .push_dat (push_dat),
        .pop_dat  (pop_dat),
        .count    (level),
        .full     (stk_full),
        .empty    (stk_empty)
    );

    assign pc_inc    = pc_next(pc_q);
    assign op_cls    = op_decode(opcode, COMC_OK);
    assign pop_page  = pop_dat[9:6];
    assign pop_pc    = pop_dat[5:0];
    assign in_sub    = !stk_empty;
    assign stack_ovf = ovf_q;

    // Stack entries and rom_addr carry the chapter bit only in 2K-ROM builds.
    generate
        if (CHAPTER_BITS > 0) begin : g_chap
            assign rom_addr = {chapter_q, page_q, pc_q};
            assign push_dat = {chapter_q, page_q, pc_inc};
            assign pop_chap = pop_dat[ADDR_W-1];
        end else begin : g_nochap
            assign rom_addr = {page_q, pc_q};
            assign push_dat = {page_q, pc_inc};
            assign pop_chap = 1'b0;
        end
    endgenerate

    always_comb begin
        pc_d      = pc_q;
        page_d    = page_q;
        pb_d      = pb_q;
        chapter_d = chapter_q;
        cb_d      = cb_q;
        ovf_d     = ovf_q;
        push      = 1'b0;
        pop       = 1'b0;
        if (step) begin
            pc_d = pc_inc;
            case (op_cls)
                OPC_LDP:  pb_d = opcode[3:0];
                OPC_COMC: cb_d = ~cb_q;
                OPC_RETN: begin
                    if (!stk_empty) begin
                        pop       = 1'b1;
                        pc_d      = pop_pc;
                        page_d    = pop_page;
                        pb_d      = pop_page;
                        chapter_d = pop_chap;
                    end else begin
                        page_d = pb_q;
                    end
                end
                OPC_BR: begin
                    if (status) begin
                        pc_d      = opcode[5:0];
                        chapter_d = cb_q;
                        // Inside a subroutine a branch stays on the current page.
                        if (stk_empty)
                            page_d = pb_q;
                    end
                end
                OPC_CALL: begin
                    if (status) begin
                        pc_d = opcode[5:0];
                        if (!stk_full) begin
                            push      = 1'b1;
                            page_d    = pb_q;
                            pb_d      = page_q;
                            chapter_d = cb_q;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        if (CHAPTER_BITS == 0) begin
            chapter_d = 1'b0;
            cb_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= '0;
            page_q    <= 4'hF;
            pb_q      <= 4'hF;
            chapter_q <= 1'b0;
            cb_q      <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            page_q    <= page_d;
            pb_q      <= pb_d;
            chapter_q <= chapter_d;
            cb_q      <= cb_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_tms1x00_seq.sv
// Directed bench for tms1x00_seq. Two builds share one stimulus stream:
// dut_a is the 1K/1-level default, dut_b is 2K with COMC and a 2-level stack.
module tb_tms1x00_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        step = 1'b0;
    logic [7:0]  opcode = 8'h00;
    logic        status = 1'b0;

    logic [9:0]  addr_a;
    logic [2:0]  level_a;
    logic        in_sub_a, ovf_a;
    logic [10:0] addr_b;
    logic [2:0]  level_b;
    logic        in_sub_b, ovf_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tms1x00_seq dut_a (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .opcode    (opcode),
        .status    (status),
        .rom_addr  (addr_a),
        .level     (level_a),
        .in_sub    (in_sub_a),
        .stack_ovf (ovf_a)
    );

    tms1x00_seq #(
        .CHAPTER_BITS (1),
        .STACK_DEPTH  (2),
        .COMC_EN      (1)
    ) dut_b (
        .clk       (clk),
        .reset     (reset),
        .step      (step),
        .opcode    (opcode),
        .status    (status),
        .rom_addr  (addr_b),
        .level     (level_b),
        .in_sub    (in_sub_b),
        .stack_ovf (ovf_b)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next
    // falling edge, i.e. half a cycle after the rising edge that used them.
    task automatic do_step(input logic [7:0] op, input logic st);
        @(negedge clk);
        step   = 1'b1;
        opcode = op;
        status = st;
        @(negedge clk);
        step   = 1'b0;
        opcode = 8'h00;
        status = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Successor written straight from the PC rule.
    function automatic logic [5:0] ref_next(input logic [5:0] pc);
        if (pc == 6'h1F) return 6'h3F;
        if (pc == 6'h3F) return 6'h3E;
        return {pc[4:0], ~(pc[5] ^ pc[4])};
    endfunction

    initial begin
        logic [5:0] exp_pc;
        logic [63:0] seen;
        int distinct;

        // Reset held with step=1: reset must win.
        step = 1'b1;
        opcode = 8'hC5;
        status = 1'b1;
        repeat (2) @(negedge clk);
        step = 1'b0;
        reset = 1'b0;
        chk_eq("reset_addr_a", 32'(addr_a), 32'h3C0);
        chk_eq("reset_addr_b", 32'(addr_b), 32'h3C0);
        chk_eq("reset_level_b", 32'(level_b), 32'd0);
        chk_eq("reset_insub_b", 32'(in_sub_b), 32'd0);
        chk_eq("reset_ovf_a", 32'(ovf_a), 32'd0);

        // Free-running PC: the sequence 00,01,03,07,0F,1F,3F,3E,... covers
        // all 64 codes once (0x3F is spliced in), so 00 recurs on step 64.
        exp_pc = 6'h00;
        seen = 64'd1;
        distinct = 1;
        for (int i = 1; i <= 64; i++) begin
            do_step(8'h00, 1'b0);
            exp_pc = ref_next(exp_pc);
            chk_eq("seq_pc", 32'(addr_a[5:0]), 32'(exp_pc));
            chk_eq("seq_page", 32'(addr_a[9:6]), 32'hF);
            if (i < 64 && !seen[addr_a[5:0]]) distinct++;
            seen[addr_a[5:0]] = 1'b1;
        end
        chk_eq("seq_distinct", 32'(distinct), 32'd64);
        chk_eq("seq_wrap_b", 32'(addr_b), 32'h3C0);

        // step=0 must hold state even with a taken branch on the bus.
        @(negedge clk);
        opcode = 8'hBF;
        status = 1'b1;
        @(negedge clk);
        opcode = 8'h00;
        status = 1'b0;
        chk_eq("hold_addr_a", 32'(addr_a), 32'h3C0);

        // LDP 3, BR 0x25 taken -> page 3, pc 0x25.
        do_step(8'h13, 1'b1);
        do_step(8'hA5, 1'b1);
        chk_eq("br_taken_a", 32'(addr_a), 32'h0E5);
        chk_eq("br_taken_b", 32'(addr_b), 32'h0E5);
        // Same pair with status=0: 0x25 -> 0x0A -> 0x15, page unchanged.
        do_step(8'h13, 1'b0);
        do_step(8'hA5, 1'b0);
        chk_eq("br_not_taken_a", 32'(addr_a), 32'h0D5);

        // Nested calls. dut_b (depth 2) nests; dut_a (depth 1) overflows on
        // the second call and only loads the PC.
        do_reset();
        do_step(8'h11, 1'b1);               // LDP 1, pc 01
        do_step(8'hD0, 1'b1);               // CALL 0x10, saves {F,03}
        chk_eq("call1_addr_b", 32'(addr_b), 32'h050);
        chk_eq("call1_level_b", 32'(level_b), 32'd1);
        chk_eq("call1_insub_b", 32'(in_sub_b), 32'd1);
        chk_eq("call1_addr_a", 32'(addr_a), 32'h050);
        do_step(8'h12, 1'b1);               // LDP 2, pc 0x20
        chk_eq("ldp2_addr_b", 32'(addr_b), 32'h060);
        do_step(8'hE0, 1'b1);               // CALL 0x20, saves {1,00}
        chk_eq("call2_addr_b", 32'(addr_b), 32'h0A0);
        chk_eq("call2_level_b", 32'(level_b), 32'd2);
        chk_eq("call2_ovf_b", 32'(ovf_b), 32'd0);
        chk_eq("ovf_addr_a", 32'(addr_a), 32'h060);
        chk_eq("ovf_level_a", 32'(level_a), 32'd1);
        chk_eq("ovf_flag_a", 32'(ovf_a), 32'd1);
        do_step(8'h0F, 1'b1);               // RETN
        chk_eq("ret1_addr_b", 32'(addr_b), 32'h040);
        chk_eq("ret1_level_b", 32'(level_b), 32'd1);
        chk_eq("ret1_addr_a", 32'(addr_a), 32'h3C3);
        do_step(8'h0F, 1'b1);               // RETN
        chk_eq("ret2_addr_b", 32'(addr_b), 32'h3C3);
        chk_eq("ret2_level_b", 32'(level_b), 32'd0);
        chk_eq("ret2_ovf_b", 32'(ovf_b), 32'd0);
        // dut_a returns at level 0: page <= pb (F), pc 03 -> 07.
        chk_eq("ret_empty_addr_a", 32'(addr_a), 32'h3C7);
        chk_eq("ret_empty_level_a", 32'(level_a), 32'd0);
        chk_eq("ovf_sticky_a", 32'(ovf_a), 32'd1);

        // Reset mid-subroutine with step=1 discards the stack and the flag.
        do_step(8'hC5, 1'b1);
        do_step(8'hC6, 1'b1);
        chk_eq("pre_reset_level_b", 32'(level_b), 32'd2);
        @(negedge clk);
        reset = 1'b1;
        step = 1'b1;
        opcode = 8'hC7;
        status = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step = 1'b0;
        status = 1'b0;
        chk_eq("mid_reset_level_b", 32'(level_b), 32'd0);
        chk_eq("mid_reset_addr_b", 32'(addr_b), 32'h3C0);
        chk_eq("mid_reset_ovf_a", 32'(ovf_a), 32'd0);

        // Chapter: COMC then BR 0x00 -> chapter 1, page = pb (F).
        do_step(8'h0B, 1'b1);
        do_step(8'h80, 1'b1);
        chk_eq("comc_addr_b", 32'(addr_b), 32'h7C0);
        chk_eq("comc_nop_addr_a", 32'(addr_a), 32'h3C0);
        do_step(8'h0B, 1'b1);
        do_step(8'h80, 1'b1);
        chk_eq("comc_back_addr_b", 32'(addr_b), 32'h3C0);

        // CALL not taken only advances the PC.
        do_step(8'hC5, 1'b0);
        chk_eq("call_nt_addr_b", 32'(addr_b), 32'h3C1);
        chk_eq("call_nt_level_b", 32'(level_b), 32'd0);
        // RETN at level 0 loads page from pb: LDP 5 (pc 03), RETN (pc 07).
        do_step(8'h15, 1'b1);
        do_step(8'h0F, 1'b1);
        chk_eq("retn_l0_addr_a", 32'(addr_a), 32'h147);
        chk_eq("retn_l0_addr_b", 32'(addr_b), 32'h147);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
